// File: rtl/usb_token_tx.sv
// USB host packet serializer: SYNC/PID/token fields with CRC5, bit stuffing,
// NRZI line coding and EOP, driven as {D+,D-} symbols with a drive enable.
module usb_token_tx #(
  parameter int CLKS_PER_BIT   = 8,
  parameter bit USB_FULL_SPEED = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [6:0] addr,
  input  logic [3:0] endp,
  output logic       busy,
  output logic       done,
  output logic [1:0] d,
  output logic       oe
);

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_PING  = 4'b0100,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_NYET  = 4'b0110
  } pid_t;

  typedef logic [1:0] d_port_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_ADDR, S_ENDP, S_CRC, S_EOP_SE0, S_EOP_J
  } state_t;

  // Low-speed idles with D- pulled high, full-speed with D+.
  localparam d_port_t LINE_J   = USB_FULL_SPEED ? 2'b10 : 2'b01;
  localparam d_port_t LINE_K   = USB_FULL_SPEED ? 2'b01 : 2'b10;
  localparam d_port_t LINE_SE0 = 2'b00;

  localparam int            BW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

  // Transmitted CRC5 field: complemented remainder, remainder MSB goes out first.
  function automatic logic [4:0] crc5_field(input logic [10:0] data);
    logic [4:0] r;
    logic [4:0] f;
    logic       fb;
    r = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = data[i] ^ r[4];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    for (int i = 0; i < 5; i++) f[i] = ~r[4-i];
    return f;
  endfunction

  state_t        state, state_n, next_field;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]    field_cnt, field_cnt_n, field_last;
  logic [2:0]    ones_cnt, ones_n;
  logic          stuffing, stuffing_n;
  logic          token_q, token_n;
  logic [30:0]   raw_q, raw_n;
  d_port_t       d_n, d_toggle;
  logic          oe_n, busy_n, done_n;
  logic          is_token, is_hs, accept;

  assign is_token = (pid[1:0] == 2'b01) || (pid == PID_PING);
  assign is_hs    = (pid[1:0] == 2'b10);
  assign accept   = (state == S_IDLE) && start && (is_token || is_hs);
  assign d_toggle = (d == LINE_J) ? LINE_K : LINE_J;

  always_comb begin
    field_last = 3'd0;
    next_field = S_IDLE;
    case (state)
      S_SYNC:    begin field_last = 3'd7; next_field = S_PID; end
      S_PID:     begin field_last = 3'd7; next_field = token_q ? S_ADDR : S_EOP_SE0; end
      S_ADDR:    begin field_last = 3'd6; next_field = S_ENDP; end
      S_ENDP:    begin field_last = 3'd3; next_field = S_CRC; end
      S_CRC:     begin field_last = 3'd4; next_field = S_EOP_SE0; end
      S_EOP_SE0: begin field_last = 3'd1; next_field = S_EOP_J; end
      default:   begin field_last = 3'd0; next_field = S_IDLE; end
    endcase
  end

  // NOTE: every variable gets a default before any branch, so no path through
  // this block can leave a value unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    field_cnt_n = field_cnt;
    ones_n      = ones_cnt;
    stuffing_n  = stuffing;
    token_n     = token_q;
    raw_n       = raw_q;
    d_n         = d;
    oe_n        = oe;
    busy_n      = busy;
    done_n      = 1'b0;

    if (state == S_IDLE) begin
      if (accept) begin
        // The first SYNC bit (raw 0) goes straight onto the line as K;
        // raw_q holds the bits that follow it, next one at index 0.
        state_n     = S_SYNC;
        bit_cnt_n   = '0;
        field_cnt_n = '0;
        ones_n      = '0;
        stuffing_n  = 1'b0;
        token_n     = is_token;
        raw_n       = {crc5_field({endp, addr}), endp, addr, ~pid, pid, 7'b100_0000};
        d_n         = LINE_K;
        oe_n        = 1'b1;
        busy_n      = 1'b1;
      end
    end else if (bit_cnt != BIT_LAST) begin
      bit_cnt_n = bit_cnt + 1'b1;
    end else begin
      bit_cnt_n = '0;
      if (!stuffing && ones_cnt == 3'd6) begin
        // Stuffed 0: field position stays put for this bit time.
        stuffing_n = 1'b1;
        ones_n     = '0;
        d_n        = d_toggle;
      end else begin
        stuffing_n = 1'b0;
        if (field_cnt == field_last) begin
          state_n     = next_field;
          field_cnt_n = '0;
        end else begin
          field_cnt_n = field_cnt + 3'd1;
        end
        case (state_n)
          S_EOP_SE0: begin d_n = LINE_SE0; ones_n = '0; end
          S_EOP_J:   begin d_n = LINE_J;   ones_n = '0; end
          S_IDLE: begin
            d_n    = LINE_J;
            oe_n   = 1'b0;
            busy_n = 1'b0;
            done_n = 1'b1;
          end
          default: begin
            raw_n = {1'b0, raw_q[30:1]};
            if (raw_q[0]) begin
              ones_n = ones_cnt + 3'd1;
            end else begin
              ones_n = '0;
              d_n    = d_toggle;
            end
          end
        endcase
      end
    end
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      field_cnt <= '0;
      ones_cnt  <= '0;
      stuffing  <= 1'b0;
      token_q   <= 1'b0;
      raw_q     <= '0;
      d         <= LINE_J;
      oe        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      field_cnt <= field_cnt_n;
      ones_cnt  <= ones_n;
      stuffing  <= stuffing_n;
      token_q   <= token_n;
      raw_q     <= raw_n;
      d         <= d_n;
      oe        <= oe_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_usb_token_tx.sv
// Directed bench for usb_token_tx: captures the line per cycle, NRZI-decodes and
// de-stuffs it, and compares against hand-computed packets and durations.
module tb_usb_token_tx;

  localparam int         CPB = 8;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       busy, done, oe;
  logic [1:0] d;

  usb_token_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .pid   (pid),
    .addr  (addr),
    .endp  (endp),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .oe    (oe)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle capture of one packet
  logic [1:0] samp[$];
  int         busy_cycles;
  bit         done_seen;
  int         oe_bad;
  logic       done_busy, done_oe;
  logic [1:0] done_d;

  task automatic launch(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    pid   = p;
    addr  = a;
    endp  = e;
    start = 1'b1;
  endtask

  // Call right after launch() at a negedge; returns on the negedge showing done.
  task automatic capture(input int poke);
    samp.delete();
    busy_cycles = 0;
    done_seen   = 1'b0;
    oe_bad      = 0;
    for (int c = 1; c <= 1000 && !done_seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == poke) begin
        pid   = PID_SETUP;
        addr  = 7'h55;
        endp  = 4'h3;
        start = 1'b1;
      end
      if (done) begin
        done_seen = 1'b1;
        done_busy = busy;
        done_oe   = oe;
        done_d    = d;
      end else begin
        samp.push_back(d);
        if (busy) busy_cycles++;
        if (!oe || !busy) oe_bad++;
      end
    end
  endtask

  task automatic analyze(input string name, input int exp_cycles, input logic [31:0] exp_raw,
                         input int exp_nraw, input int exp_stuffs, input int exp_first);
    int         nsym, ones, nraw, stuffs, first, hold_bad, line_bad;
    bit         skip;
    logic [1:0] prev, s;
    logic [31:0] raw;
    logic       b;
    nsym = samp.size() / CPB;
    check({name, "_done"}, done_seen, 1'b1);
    check({name, "_busy_cycles"}, busy_cycles, exp_cycles);
    check({name, "_oe"}, oe_bad, 0);
    check({name, "_end_state"}, {done_busy, done_oe, done_d}, {1'b0, 1'b0, J});
    hold_bad = 0;
    for (int i = 0; i < nsym * CPB; i++)
      if (samp[i] !== samp[(i / CPB) * CPB + CPB / 2]) hold_bad++;
    check({name, "_symbol_hold"}, hold_bad, 0);
    if (nsym >= 3)
      check({name, "_eop"}, {samp[(nsym-3)*CPB + CPB/2], samp[(nsym-2)*CPB + CPB/2],
                             samp[(nsym-1)*CPB + CPB/2]}, {SE0, SE0, J});
    prev = J; ones = 0; skip = 1'b0; nraw = 0; stuffs = 0; first = -1; line_bad = 0; raw = '0;
    for (int k = 0; k < nsym - 3; k++) begin
      s = samp[k*CPB + CPB/2];
      if (s != J && s != K) line_bad++;
      b    = (s == prev);
      prev = s;
      if (skip) begin
        skip = 1'b0;
        stuffs++;
        if (first < 0) first = k;
        if (b) line_bad++;
        ones = 0;
      end else begin
        if (nraw < 32) raw[nraw] = b;
        nraw++;
        ones = b ? ones + 1 : 0;
        if (ones == 6) skip = 1'b1;
      end
    end
    check({name, "_raw_bits"}, raw, exp_raw);
    check({name, "_raw_count"}, nraw, exp_nraw);
    check({name, "_stuff_count"}, stuffs, exp_stuffs);
    check({name, "_first_stuff_sym"}, first, exp_first);
    check({name, "_line_symbols"}, line_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         bad;
    logic [15:0] sync_line;
    reset = 1'b1;
    start = 1'b0;
    pid   = '0;
    addr  = '0;
    endp  = '0;
    #1;
    check("reset_outputs", {busy, oe, d, done}, {1'b0, 1'b0, J, 1'b0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, oe, d, done}, {1'b0, 1'b0, J, 1'b0});

    // SETUP addr 0 endp 0: bytes 80 2D 00 10, no stuffing
    launch(PID_SETUP, 7'h00, 4'h0);
    capture(-1);
    analyze("setup", 280, 32'h1000_2D80, 32, 0, -1);
    sync_line = '0;
    for (int k = 0; k < 8 && k * CPB + CPB / 2 < samp.size(); k++)
      sync_line[15-2*k -: 2] = samp[k*CPB + CPB/2];
    check("setup_sync_line", sync_line, {K, J, K, J, K, J, K, K});
    @(negedge clk);
    check("setup_done_width", {done, d}, {1'b0, J});

    // ACK with a stray start pulsed mid-packet
    repeat (3) @(negedge clk);
    launch(PID_ACK, 7'h00, 4'h0);
    capture(40);
    analyze("ack", 152, 32'h0000_D280, 16, 0, -1);

    // IN addr 7F endp F: one stuff after sixth address 1, crc field 0x08
    repeat (3) @(negedge clk);
    launch(PID_IN, 7'h7F, 4'hF);
    capture(-1);
    analyze("in_7f", 288, 32'h47FF_6980, 32, 1, 22);

    // DATA0 is not a token or handshake: start must be ignored
    repeat (3) @(negedge clk);
    launch(PID_DATA0, 7'h12, 4'h3);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || oe || done || d !== J) bad++;
    end
    check("data0_ignored", bad, 0);

    // Back-to-back: SOF requested in the done cycle of an ACK
    launch(PID_ACK, 7'h00, 4'h0);
    capture(-1);
    analyze("b2b_ack", 152, 32'h0000_D280, 16, 0, -1);
    launch(PID_SOF, 7'h7F, 4'hF);
    capture(-1);
    check("b2b_first_k", samp.size() > 0 ? samp[0] : 2'bxx, K);
    analyze("b2b_sof", 296, 32'h47FF_A580, 32, 2, 21);

    // Reset in the ADDR field, then SOF frame 0x7FF
    repeat (3) @(negedge clk);
    launch(PID_IN, 7'h7F, 4'hF);
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", {busy, oe}, 2'b11);
    reset = 1'b1;
    #1;
    check("async_reset", {busy, oe, d}, {1'b0, 1'b0, J});
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) bad++;
    end
    check("reset_no_done", bad, 0);
    reset = 1'b0;
    @(negedge clk);
    launch(PID_SOF, 7'h7F, 4'hF);
    capture(-1);
    analyze("sof_after_reset", 296, 32'h47FF_A580, 32, 2, 21);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
